// File: rtl/dab_pkg.sv
// ---------------------------------------------------------------------------
// dab_pkg
// Shared definitions for the dual-active-bridge phase-shift modulator:
//   CNT_W       width of the period counter and every configuration field
//   LVL_*       three-level bridge command encodings (+1, 0, -1)
//   mod_state_t modulator state encoding
//   dab_cfg_t   configuration record {period, phase, duty1, duty2}
//   sanitize_cfg  clears the period LSB and clamps duty/phase into range
// ---------------------------------------------------------------------------
package dab_pkg;

    localparam int CNT_W = 16;

    localparam logic signed [1:0] LVL_P1 = 2'sb01;
    localparam logic signed [1:0] LVL_0  = 2'sb00;
    localparam logic signed [1:0] LVL_N1 = 2'sb11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mod_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] phase;
        logic [CNT_W-1:0] duty1;
        logic [CNT_W-1:0] duty2;
    } dab_cfg_t;

    // Forces an even period so the two half periods are equal, then clamps
    // each duty to one half period and the phase to the last position.
    function automatic dab_cfg_t sanitize_cfg(input dab_cfg_t raw);
        dab_cfg_t         c;
        logic [CNT_W-1:0] half;
        c        = raw;
        c.period = {raw.period[CNT_W-1:1], 1'b0};
        half     = c.period >> 1;
        if (raw.duty1 > half) c.duty1 = half;
        if (raw.duty2 > half) c.duty2 = half;
        if (raw.phase >= c.period) c.phase = c.period - CNT_W'(1);
        return c;
    endfunction

endpackage

// File: rtl/bridge_level_gen.sv
// ---------------------------------------------------------------------------
// bridge_level_gen
// Combinational three-level command for one bridge.
//   pos   in  position within the period, 0 .. T_eff-1
//   half  in  T_eff / 2
//   duty  in  positive/negative level width per half period (<= half)
//   level out +1 for pos < duty, -1 for half <= pos < half+duty, else 0
// ---------------------------------------------------------------------------
module bridge_level_gen
    import dab_pkg::*;
(
    input  logic [CNT_W-1:0]  pos,
    input  logic [CNT_W-1:0]  half,
    input  logic [CNT_W-1:0]  duty,
    output logic signed [1:0] level
);

    always_comb begin
        level = LVL_0;
        if (pos < duty) begin
            level = LVL_P1;
        // Offset compare avoids forming half+duty, which could overflow.
        end else if (pos >= half && (pos - half) < duty) begin
            level = LVL_N1;
        end
    end

endmodule

// File: rtl/dab_phase_shift_modulator.sv
// ---------------------------------------------------------------------------
// dab_phase_shift_modulator
// Triple-phase-shift modulator producing the primary (V1) and secondary (V2)
// three-level bridge commands once per switching period.
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              run request, sampled every cycle
//   trip                emergency stop, level-sensitive, overrides everything
//   cfg_valid/cfg_ready configuration handshake
//   cfg_period/phase/duty1/duty2  configuration fields (clk cycles)
//   cfg_err             one-cycle pulse when an offered period is too short
//   V1, V2              registered bridge levels (+1/0/-1, 2-bit signed)
//   sync                one-cycle pulse with the first output of each period
//   running             high while in RUN
// A configuration is accepted into a pending register and becomes active on
// the next period boundary (or immediately when idle).
// ---------------------------------------------------------------------------
module dab_phase_shift_modulator
    import dab_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              trip,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic [CNT_W-1:0]  cfg_duty1,
    input  logic [CNT_W-1:0]  cfg_duty2,
    output logic              cfg_err,
    output logic signed [1:0] V1,
    output logic signed [1:0] V2,
    output logic              sync,
    output logic              running
);

    mod_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dab_cfg_t          pend_q, pend_d;
    dab_cfg_t          act_q, act_d;
    logic              pend_valid_q, pend_valid_d;
    logic              loaded_q, loaded_d;
    logic              cfg_err_q, cfg_err_d;
    logic              sync_q, sync_d;
    logic signed [1:0] v1_q, v1_d;
    logic signed [1:0] v2_q, v2_d;

    dab_cfg_t          cfg_in;
    dab_cfg_t          cfg_clean;
    logic              cfg_fire;
    logic              cfg_bad;
    logic [CNT_W-1:0]  half_act;
    logic [CNT_W-1:0]  pos2;
    logic              at_wrap;
    logic              apply;
    logic signed [1:0] lvl1;
    logic signed [1:0] lvl2;

    // The pending slot holds at most one set; it frees once applied.
    assign cfg_ready = !pend_valid_q;
    assign cfg_fire  = cfg_valid && cfg_ready;

    always_comb begin
        cfg_in    = '{period: cfg_period, phase: cfg_phase,
                      duty1: cfg_duty1, duty2: cfg_duty2};
        cfg_clean = sanitize_cfg(cfg_in);
        cfg_bad   = cfg_clean.period < CNT_W'(4);
    end

    assign half_act = act_q.period >> 1;
    assign at_wrap  = (cnt_q == act_q.period - CNT_W'(1));

    // Bridge 2 position: (cnt - phase) mod T_eff. Both operands are below
    // T_eff, so a single conditional add of T_eff restores the range.
    always_comb begin
        pos2 = cnt_q - act_q.phase;
        if (cnt_q < act_q.phase) pos2 = pos2 + act_q.period;
    end

    bridge_level_gen u_level1 (
        .pos   (cnt_q),
        .half  (half_act),
        .duty  (act_q.duty1),
        .level (lvl1)
    );

    bridge_level_gen u_level2 (
        .pos   (pos2),
        .half  (half_act),
        .duty  (act_q.duty2),
        .level (lvl2)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        act_d        = act_q;
        loaded_d     = loaded_q;
        cfg_err_d    = 1'b0;
        sync_d       = 1'b0;
        v1_d         = LVL_0;
        v2_d         = LVL_0;
        apply        = 1'b0;

        if (cfg_fire) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_d       = cfg_clean;
                pend_valid_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                apply = pend_valid_q && !trip;
                if (enable && loaded_q && !trip) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (trip) begin
                    // Output register is forced to zero here, so the trip
                    // reaches V1/V2 with no added latency.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    v1_d   = lvl1;
                    v2_d   = lvl2;
                    sync_d = (cnt_q == '0);
                    if (at_wrap) begin
                        cnt_d = '0;
                        apply = pend_valid_q;
                        if (!enable) state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (apply) begin
            act_d        = pend_q;
            loaded_d     = 1'b1;
            pend_valid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            // NOTE: the configuration registers are reset as well; together
            // with loaded_q this guarantees no stale set survives a reset.
            pend_q       <= '0;
            act_q        <= '0;
            pend_valid_q <= 1'b0;
            loaded_q     <= 1'b0;
            cfg_err_q    <= 1'b0;
            sync_q       <= 1'b0;
            v1_q         <= LVL_0;
            v2_q         <= LVL_0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            act_q        <= act_d;
            pend_valid_q <= pend_valid_d;
            loaded_q     <= loaded_d;
            cfg_err_q    <= cfg_err_d;
            sync_q       <= sync_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
        end
    end

    assign V1      = v1_q;
    assign V2      = v2_q;
    assign sync    = sync_q;
    assign cfg_err = cfg_err_q;
    assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_dab_phase_shift_modulator.sv
// ---------------------------------------------------------------------------
// tb_dab_phase_shift_modulator
// Directed stimulus with literal expectations at key points, plus a
// cycle-level reference model (period start index + modular arithmetic)
// compared against every DUT output on each falling clock edge.
// ---------------------------------------------------------------------------
module tb_dab_phase_shift_modulator;
    import dab_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              enable = 1'b0;
    logic              trip = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CNT_W-1:0]  cfg_period = '0;
    logic [CNT_W-1:0]  cfg_phase = '0;
    logic [CNT_W-1:0]  cfg_duty1 = '0;
    logic [CNT_W-1:0]  cfg_duty2 = '0;
    logic              cfg_err;
    logic signed [1:0] V1;
    logic signed [1:0] V2;
    logic              sync;
    logic              running;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    dab_phase_shift_modulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .trip       (trip),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_phase  (cfg_phase),
        .cfg_duty1  (cfg_duty1),
        .cfg_duty2  (cfg_duty2),
        .cfg_err    (cfg_err),
        .V1         (V1),
        .V2         (V2),
        .sync       (sync),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Level at position p of a period T with duty d: the position within its
    // half period decides "active", the half decides the sign.
    function automatic int level_at(input int p, input int d, input int t);
        int h = t / 2;
        if ((p % h) < d) return (p < h) ? 1 : -1;
        return 0;
    endfunction

    int cyc, m_start, m_t, m_ph, m_d1, m_d2, p_t, p_ph, p_d1, p_d2;
    bit m_run, m_loaded, m_pend;
    int e_v1, e_v2;
    bit e_sync, e_run, e_ready, e_err;

    int n_cyc, n_start, n_t, n_ph, n_d1, n_d2, np_t, np_ph, np_d1, np_d2;
    bit n_run, n_loaded, n_pend;
    int n_v1, n_v2;
    bit n_sync, n_err;

    always @* begin : model_next
        int pos;
        int teff;
        bit fire;
        bit wrap;
        bit apply;
        n_cyc = cyc + 1;  n_start = m_start; n_run = m_run;
        n_loaded = m_loaded; n_pend = m_pend;
        n_t = m_t;   n_ph = m_ph;   n_d1 = m_d1;   n_d2 = m_d2;
        np_t = p_t;  np_ph = p_ph;  np_d1 = p_d1;  np_d2 = p_d2;
        n_v1 = 0; n_v2 = 0; n_sync = 1'b0;
        pos = 0; wrap = 1'b0;
        teff = int'(cfg_period) - int'(cfg_period) % 2;
        fire = cfg_valid && !m_pend;
        n_err = fire && (teff < 4);
        if (m_run) begin
            pos  = (cyc - m_start) % m_t;
            wrap = (pos == m_t - 1);
            if (!trip) begin
                n_v1   = level_at(pos, m_d1, m_t);
                n_v2   = level_at(((pos - m_ph) % m_t + m_t) % m_t, m_d2, m_t);
                n_sync = (pos == 0);
            end
        end
        apply = m_pend && !trip && (!m_run || wrap);
        if (m_run) begin
            if (trip) n_run = 1'b0;
            else if (wrap) begin
                n_start = cyc + 1;
                if (!enable) n_run = 1'b0;
            end
        end else if (enable && m_loaded && !trip) begin
            n_run   = 1'b1;
            n_start = cyc + 1;
        end
        if (apply) begin
            n_t = p_t; n_ph = p_ph; n_d1 = p_d1; n_d2 = p_d2;
            n_loaded = 1'b1;
            n_pend   = 1'b0;
        end
        if (fire && teff >= 4) begin
            np_t  = teff;
            np_d1 = (int'(cfg_duty1) > teff / 2) ? teff / 2 : int'(cfg_duty1);
            np_d2 = (int'(cfg_duty2) > teff / 2) ? teff / 2 : int'(cfg_duty2);
            np_ph = (int'(cfg_phase) >= teff) ? teff - 1 : int'(cfg_phase);
            n_pend = 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; m_start <= 0; m_run <= 1'b0; m_loaded <= 1'b0; m_pend <= 1'b0;
            m_t <= 0; m_ph <= 0; m_d1 <= 0; m_d2 <= 0;
            p_t <= 0; p_ph <= 0; p_d1 <= 0; p_d2 <= 0;
            e_v1 <= 0; e_v2 <= 0; e_sync <= 1'b0; e_run <= 1'b0;
            e_ready <= 1'b1; e_err <= 1'b0;
        end else begin
            cyc <= n_cyc; m_start <= n_start; m_run <= n_run;
            m_loaded <= n_loaded; m_pend <= n_pend;
            m_t <= n_t; m_ph <= n_ph; m_d1 <= n_d1; m_d2 <= n_d2;
            p_t <= np_t; p_ph <= np_ph; p_d1 <= np_d1; p_d2 <= np_d2;
            e_v1 <= n_v1; e_v2 <= n_v2; e_sync <= n_sync; e_run <= n_run;
            e_ready <= !n_pend; e_err <= n_err;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_v1",      int'(V1),        e_v1);
            check("model_v2",      int'(V2),        e_v2);
            check("model_sync",    int'(sync),      int'(e_sync));
            check("model_running", int'(running),   int'(e_run));
            check("model_ready",   int'(cfg_ready), int'(e_ready));
            check("model_err",     int'(cfg_err),   int'(e_err));
        end
    end

    // ---------------- stimulus helpers (called at falling edges) ----------------
    task automatic wait_ready(input int budget, input string name);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cfg_ready !== 1'b1) check({name, "_timeout"}, int'(cfg_ready), 1);
    endtask

    task automatic wait_sync(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sync !== 1'b1 && n < budget);
        if (sync !== 1'b1) check({name, "_timeout"}, int'(sync), 1);
    endtask

    task automatic measure_period(input string name, input int exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sync !== 1'b1 && n < 300);
        check(name, n, exp);
    endtask

    task automatic load_cfg(input int t, input int ph, input int d1, input int d2);
        wait_ready(400, "load_ready");
        cfg_period = CNT_W'(t);
        cfg_phase  = CNT_W'(ph);
        cfg_duty1  = CNT_W'(d1);
        cfg_duty2  = CNT_W'(d2);
        cfg_valid  = 1'b1;
        @(negedge clk);
        cfg_valid  = 1'b0;
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3 rst_n = 1'b0;
        cmp_on = 1'b1;
        skip(2);
        check("rst_v1", int'(V1), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_running", int'(running), 0);
        rst_n = 1'b1;
        skip(1);

        // Square wave, T=100, phase 25
        load_cfg(100, 25, 50, 50);
        wait_ready(10, "idle_apply");
        enable = 1'b1;
        skip(2);
        check("start_sync", int'(sync), 1);
        check("sq_v1_c0", int'(V1), 1);
        check("sq_v2_c0", int'(V2), -1);
        skip(25);
        check("sq_v1_c25", int'(V1), 1);
        check("sq_v2_c25", int'(V2), 1);
        skip(25);
        check("sq_v1_c50", int'(V1), -1);
        check("sq_v2_c50", int'(V2), 1);
        wait_sync(120, "sq_sync");
        measure_period("sq_period", 100);

        // Double-buffered phase update offered at cnt=30
        skip(29);
        load_cfg(100, 50, 50, 50);
        check("upd_ready_low", int'(cfg_ready), 0);
        wait_sync(120, "upd_sync");
        check("upd_ready_high", int'(cfg_ready), 1);
        skip(25);
        check("upd_v2_c25", int'(V2), -1);
        check("upd_v1_c25", int'(V1), 1);

        // Rejected period
        load_cfg(3, 0, 0, 0);
        check("rej_err", int'(cfg_err), 1);
        check("rej_ready", int'(cfg_ready), 1);

        // Three-level duty, T=40
        load_cfg(40, 0, 10, 0);
        wait_ready(150, "tl_ready");
        wait_sync(5, "tl_sync");
        measure_period("tl_period", 40);
        check("tl_v1_c0", int'(V1), 1);
        check("tl_v2_c0", int'(V2), 0);
        skip(10);
        check("tl_v1_c10", int'(V1), 0);
        skip(10);
        check("tl_v1_c20", int'(V1), -1);
        skip(10);
        check("tl_v1_c30", int'(V1), 0);
        check("tl_v2_c30", int'(V2), 0);

        // Clamping: T=21 -> 20, d1 30 -> 10, phase 40 -> 19
        load_cfg(21, 40, 30, 5);
        wait_ready(60, "cl_ready");
        wait_sync(5, "cl_sync");
        measure_period("cl_period", 20);
        check("cl_v1_c0", int'(V1), 1);
        check("cl_v2_c0", int'(V2), 1);
        skip(4);
        check("cl_v2_c4", int'(V2), 0);
        skip(6);
        check("cl_v1_c10", int'(V1), -1);

        // Trip at cnt=37
        load_cfg(100, 25, 50, 50);
        wait_ready(40, "tr_ready");
        wait_sync(5, "tr_sync");
        skip(36);
        trip = 1'b1;
        skip(1);
        check("trip_v1", int'(V1), 0);
        check("trip_v2", int'(V2), 0);
        check("trip_running", int'(running), 0);
        skip(20);
        check("trip_hold_running", int'(running), 0);
        check("trip_hold_v1", int'(V1), 0);
        trip = 1'b0;

        // Stop at cnt=10, period completes, then restart
        wait_sync(10, "st_sync");
        skip(9);
        enable = 1'b0;
        skip(90);
        check("stop_last_v1", int'(V1), -1);
        skip(1);
        check("stop_v1_zero", int'(V1), 0);
        check("stop_running", int'(running), 0);
        enable = 1'b1;
        skip(2);
        check("restart_sync", int'(sync), 1);
        skip(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dab_phase_shift_modulator.md
# dab_phase_shift_modulator

Triple-phase-shift modulator for the dual-active-bridge converter. Generates the three-level bridge commands V1 (primary) and V2 (secondary) once per switching period from a period, a phase shift and two duty values. Feeds the H-bridge switching block, which inserts deadtime and drives the gates. Configuration updates are double-buffered and applied only at period boundaries; a trip input forces both bridges to the zero level immediately.

## Interface
- CNT_W, 16, width of the period counter and of all configuration fields
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; sampled every cycle
- trip  in  1  emergency stop, level-sensitive, overrides enable
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration can be accepted
- cfg_period  in  CNT_W  switching period T in clk cycles
- cfg_phase  in  CNT_W  phase shift of bridge 2 relative to bridge 1, in cycles
- cfg_duty1 / cfg_duty2  in  CNT_W  positive-level width per half period, bridges 1/2
- cfg_err  out  1  one-cycle pulse: offered configuration rejected
- V1 / V2  out  2 signed  bridge level: +1 = 2'sb01, 0 = 2'sb00, -1 = 2'sb11
- sync  out  1  one-cycle pulse with the first output cycle of every period
- running  out  1  high while in RUN

## Operation
- Reset values: V1=V2=0, sync=0, cfg_err=0, running=0, cfg_ready=1, cnt=0, state IDLE, no configuration loaded.
- Transfer occurs when cfg_valid && cfg_ready. Checked at acceptance:
  - T_eff = cfg_period with LSB cleared; half = T_eff/2.
  - T_eff < 4: rejected; cfg_err pulses next cycle; cfg_ready stays 1; pending unchanged.
  - Duty > half is clamped to half. Phase ≥ T_eff is clamped to T_eff-1.
  - The accepted set goes to the pending register. cfg_ready drops the next cycle and stays low until the set is applied.
- Application of the pending set:
  - In IDLE: applied on the cycle after acceptance.
  - In RUN: applied on the wrap cycle (cnt goes T_eff-1 → 0).
  - cfg_ready returns to 1 on the cycle after application.
- Level rule for position p in [0,T_eff), duty d:
  - +1 for p < d
  - 0 for d ≤ p < half
  - -1 for half ≤ p < half+d
  - 0 otherwise
  - d=0 gives a constant 0; d=half gives a two-level square wave.
- Bridge positions: bridge 1 uses p1 = cnt. Bridge 2 uses p2 = (cnt − phase) mod T_eff, computed without division (conditional add of T_eff).
- State machine:
  - IDLE: cnt=0, V=0. Goes to RUN when enable && loaded && !trip.
  - RUN: cnt increments each cycle and wraps at T_eff-1. At wrap with enable=0, goes to IDLE (the period always completes). trip=1 goes to IDLE on the next cycle.
- Trip:
  - Wins over enable, cfg application and wrap.
  - A pending configuration is retained through a trip.
  - While trip=1, IDLE never exits.
- Reset mid-operation: all state returns to reset values asynchronously; loaded is cleared.

## Timing
- V1, V2 and sync are registered: outputs in cycle n+1 reflect cnt of cycle n.
- Start: enable sampled high at edge n → cnt=0 in cycle n+1 → sync=1 and V for cnt=0 in cycle n+2.
- Normal stop: the last registered outputs for cnt=T_eff-1 are emitted, then V=0 from the following cycle.
- Trip: sampled at edge n → V1=V2=0, running=0 from cycle n+1. The output register is overridden, so there is no extra latency.
- New configuration in RUN: takes effect exactly at the first sync after acceptance. A configuration accepted on the wrap cycle itself waits one full period.

## Structure
- Shared package dab_pkg:
  - level constants LVL_P1, LVL_0, LVL_N1
  - modulator state encoding (IDLE, RUN)
  - config record typedef {period, phase, duty1, duty2}
- Sub-module bridge_level_gen, instantiated twice:
  - inputs: position, half, duty
  - output: combinational 2-bit signed level
- Top level holds the FSM, counter, pending/active registers, phase subtraction and output registers.

## Test plan
- Square-wave phase shift: load T=100, d1=d2=50, phase=25, enable.
  - V1 = +1 for cnt 0–49, −1 for cnt 50–99.
  - V2 = +1 for cnt 25–74, −1 for cnt 75–99 and 0–24.
  - sync every 100 cycles.
- Three-level duty: T=40, d1=10, d2=0, phase=0.
  - V1 = +1 for 0–9, 0 for 10–19, −1 for 20–29, 0 for 30–39.
  - V2 constant 0.
- Double-buffered update: in RUN with T=100, offer phase=50 at cnt=30.
  - cfg_ready low until wrap.
  - Phase changes exactly at the next sync.
  - cfg_ready high one cycle after.
- Validation and clamping:
  - T=3 → cfg_err pulse, outputs unchanged.
  - T=21, d1=30, phase=40 → applied as T_eff=20, d1=10, phase=19.
- Trip mid-period: trip at cnt=37 → V1=V2=0 next cycle, running=0. Enable held high with trip held high → remains IDLE.
- Stop and restart: drop enable at cnt=10 → period completes to cnt=99, then V=0. Re-enable → sync 2 cycles after enable.
